// File: rtl/shift_rotate_pkg.sv
// Shared types for the multi-cycle shift/rotate engine: op encoding, FSM states, op legality.
package shift_rotate_pkg;

    typedef enum logic [2:0] {
        SHR_OP  = 3'b000,
        SHRA_OP = 3'b001,
        SHL_OP  = 3'b010,
        ROR_OP  = 3'b011,
        ROL_OP  = 3'b100
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= 3'b100;
    endfunction

endpackage

// File: rtl/shift_rotate_unit_step.sv
// Combinational single-step shifter: moves a WIDTH-bit value by k in [0, STEP] positions.
// The carry-out port exists only when SHIFT_UNIT_CARRY_EN is defined.
module shift_step
    import shift_rotate_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    parameter int unsigned KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [2:0]       i_op,
    input  logic [KW-1:0]    i_k,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_value
`ifdef SHIFT_UNIT_CARRY_EN
    ,
    output logic             o_carry
`endif
);

    logic [2*WIDTH-1:0] w_dbl;

    always_comb begin
        w_dbl   = '0;
        o_value = i_value;
        unique case (i_op)
            SHR_OP, SHRA_OP: begin
                w_dbl   = {{WIDTH{i_fill}}, i_value} >> i_k;
                o_value = w_dbl[WIDTH-1:0];
            end
            SHL_OP: begin
                w_dbl   = {{WIDTH{1'b0}}, i_value} << i_k;
                o_value = w_dbl[WIDTH-1:0];
            end
            ROR_OP: begin
                w_dbl   = {i_value, i_value} >> i_k;
                o_value = w_dbl[WIDTH-1:0];
            end
            ROL_OP: begin
                w_dbl   = {i_value, i_value} << i_k;
                o_value = w_dbl[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

`ifdef SHIFT_UNIT_CARRY_EN
    localparam int unsigned AW = $clog2(WIDTH);

    // Index of the last bit to leave the word; unused when k is zero.
    logic [AW-1:0] w_ridx;
    logic [AW-1:0] w_lidx;
    assign w_ridx = AW'(int'(i_k) - 1);
    assign w_lidx = AW'(int'(WIDTH) - int'(i_k));

    always_comb begin
        o_carry = 1'b0;
        unique case (i_op)
            SHR_OP, SHRA_OP: o_carry = (i_k != '0) && i_value[w_ridx];
            SHL_OP:          o_carry = (i_k != '0) && i_value[w_lidx];
            ROR_OP:          o_carry = o_value[WIDTH-1];
            ROL_OP:          o_carry = o_value[0];
            default:         o_carry = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/shift_rotate_unit.sv
// Iterative SHR/SHRA/SHL/ROR/ROL engine, STEP positions per clock, start/busy/done handshake.
// Define SHIFT_UNIT_CARRY_EN to add the o_cout port and its tracking register.
module shift_rotate_unit
    import shift_rotate_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic                     i_clock,
    input  logic                     i_clear,
    input  logic                     i_start,
    input  logic [2:0]               i_op,
    input  logic [WIDTH-1:0]         i_a,
    input  logic [$clog2(WIDTH)-1:0] i_amount,
    output logic [WIDTH-1:0]         o_result,
    output logic                     o_busy,
    output logic                     o_done
`ifdef SHIFT_UNIT_CARRY_EN
    ,
    output logic                     o_cout
`endif
);

    localparam int unsigned AW = $clog2(WIDTH);
    localparam int unsigned KW = $clog2(STEP + 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_d;
    logic [2:0]       r_op;
    logic [2:0]       w_op_d;
    logic             r_fill;
    logic             w_fill_d;
    logic [AW-1:0]    r_remaining;
    logic [AW-1:0]    w_remaining_d;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_d;
    logic [KW-1:0]    w_k;
    logic [WIDTH-1:0] w_step_value;

    always_comb begin
        if (r_remaining > AW'(STEP)) begin
            w_k = KW'(STEP);
        end else begin
            w_k = KW'(r_remaining);
        end
    end

`ifdef SHIFT_UNIT_CARRY_EN
    logic r_cout;
    logic w_cout_d;
    logic w_step_carry;
`endif

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .i_value (r_work),
        .i_op    (r_op),
        .i_k     (w_k),
        .i_fill  (r_fill),
        .o_value (w_step_value)
`ifdef SHIFT_UNIT_CARRY_EN
        ,
        .o_carry (w_step_carry)
`endif
    );

    always_comb begin
        w_state_d     = r_state;
        w_work_d      = r_work;
        w_op_d        = r_op;
        w_fill_d      = r_fill;
        w_remaining_d = r_remaining;
        w_result_d    = r_result;
`ifdef SHIFT_UNIT_CARRY_EN
        w_cout_d      = r_cout;
`endif
        case (r_state)
            SHIFT: begin
                w_work_d      = w_step_value;
                w_remaining_d = r_remaining - AW'(w_k);
                if (w_remaining_d == '0) begin
                    w_state_d  = DONE;
                    w_result_d = w_step_value;
`ifdef SHIFT_UNIT_CARRY_EN
                    w_cout_d   = w_step_carry;
`endif
                end
            end
            // IDLE and DONE both accept; start is ignored while shifting.
            default: begin
                if (i_start) begin
                    w_work_d      = i_a;
                    w_op_d        = i_op;
                    w_fill_d      = (i_op == SHRA_OP) && i_a[WIDTH-1];
                    w_remaining_d = i_amount;
                    if ((i_amount != '0) && is_legal_op(i_op)) begin
                        w_state_d = SHIFT;
                    end else begin
                        w_state_d  = DONE;
                        w_result_d = i_a;
`ifdef SHIFT_UNIT_CARRY_EN
                        w_cout_d   = 1'b0;
`endif
                    end
                end else begin
                    w_state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_op        <= '0;
            r_fill      <= 1'b0;
            r_remaining <= '0;
            r_result    <= '0;
        end else begin
            r_state     <= w_state_d;
            r_work      <= w_work_d;
            r_op        <= w_op_d;
            r_fill      <= w_fill_d;
            r_remaining <= w_remaining_d;
            r_result    <= w_result_d;
        end
    end

`ifdef SHIFT_UNIT_CARRY_EN
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_cout <= 1'b0;
        end else begin
            r_cout <= w_cout_d;
        end
    end

    assign o_cout = r_cout;
`endif

    assign o_result = r_result;
    assign o_busy   = (r_state == SHIFT);
    assign o_done   = (r_state == DONE);

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Scoreboard bench for shift_rotate_unit: one STEP=1 and one STEP=4 instance, WIDTH=32.
module tb_shift_rotate_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        clear1, start1, busy1, done1;
    logic [2:0]  op1;
    logic [31:0] a1, res1;
    logic [4:0]  amt1;
    logic        clear4, start4, busy4, done4;
    logic [2:0]  op4;
    logic [31:0] a4, res4;
    logic [4:0]  amt4;
`ifdef SHIFT_UNIT_CARRY_EN
    logic        cout1, cout4;
`endif

    shift_rotate_unit #(.WIDTH(32), .STEP(1)) u_dut1 (
        .i_clock  (clk),
        .i_clear  (clear1),
        .i_start  (start1),
        .i_op     (op1),
        .i_a      (a1),
        .i_amount (amt1),
        .o_result (res1),
        .o_busy   (busy1),
        .o_done   (done1)
`ifdef SHIFT_UNIT_CARRY_EN
        ,
        .o_cout   (cout1)
`endif
    );

    shift_rotate_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
        .i_clock  (clk),
        .i_clear  (clear4),
        .i_start  (start4),
        .i_op     (op4),
        .i_a      (a4),
        .i_amount (amt4),
        .o_result (res4),
        .o_busy   (busy4),
        .o_done   (done4)
`ifdef SHIFT_UNIT_CARRY_EN
        ,
        .o_cout   (cout4)
`endif
    );

    typedef struct {
        logic [31:0] res;
        logic        cout;
        int          acc;
        int          lat;
        string       name;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;
    int   bc1 = 0;
    int   bc4 = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: on every done, pop the oldest expectation and compare result, latency, busy span.
    task automatic mon(input bit sel);
        logic        b, d, c;
        logic [31:0] r;
        int          bc;
        exp_t        e;
        bit          empty;
        b  = sel ? busy4 : busy1;
        d  = sel ? done4 : done1;
        r  = sel ? res4 : res1;
        bc = sel ? bc4 : bc1;
`ifdef SHIFT_UNIT_CARRY_EN
        c  = sel ? cout4 : cout1;
`else
        c  = 1'b0;
`endif
        empty = sel ? (q4.size() == 0) : (q1.size() == 0);
        if (d) begin
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done dut_step=%0d got=done exp=no_done", sel ? 4 : 1);
            end else begin
                if (sel) e = q4.pop_front();
                else     e = q1.pop_front();
                check({e.name, "_result"}, r, e.res);
                check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
                check({e.name, "_busy_cycles"}, 32'(bc), 32'(e.lat));
                check({e.name, "_busy_with_done"}, {31'b0, b}, 32'd0);
`ifdef SHIFT_UNIT_CARRY_EN
                check({e.name, "_cout"}, {31'b0, c}, {31'b0, e.cout});
`endif
            end
            bc = 0;
        end else if (b) begin
            bc++;
        end else begin
            bc = 0;
        end
        if (c === 1'bx) bc = bc;
        if (sel) bc4 = bc;
        else     bc1 = bc;
    endtask

    always @(negedge clk) begin
        mon(1'b0);
        mon(1'b1);
    end

    // Called on a negedge; the request is accepted at the following posedge.
    task automatic launch(input bit sel, input logic [2:0] op, input logic [31:0] a,
                          input logic [4:0] amt, input logic [31:0] res, input logic cout,
                          input int lat, input string name, input bit push);
        exp_t e;
        e.res  = res;
        e.cout = cout;
        e.acc  = cyc + 1;
        e.lat  = lat;
        e.name = name;
        if (sel) begin
            start4 = 1'b1; op4 = op; a4 = a; amt4 = amt;
            if (push) q4.push_back(e);
        end else begin
            start1 = 1'b1; op1 = op; a1 = a; amt1 = amt;
            if (push) q1.push_back(e);
        end
        @(negedge clk);
        if (sel) begin
            start4 = 1'b0; a4 = ~a; amt4 = ~amt; op4 = 3'b111;
        end else begin
            start1 = 1'b0; a1 = ~a; amt1 = ~amt; op1 = 3'b111;
        end
    endtask

    task automatic wait_done(input bit sel, input string name);
        int n = 0;
        while (!(sel ? done4 : done1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(sel ? done4 : done1)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=no_done exp=done", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear1 = 1'b1; start1 = 1'b0; op1 = 3'b000; a1 = '0; amt1 = '0;
        clear4 = 1'b1; start4 = 1'b0; op4 = 3'b000; a4 = '0; amt4 = '0;
        repeat (3) @(negedge clk);
        check("reset_result1", res1, 32'h0);
        check("reset_busy1", {31'b0, busy1}, 32'h0);
        check("reset_done1", {31'b0, done1}, 32'h0);
        check("reset_result4", res4, 32'h0);
        check("reset_busy4", {31'b0, busy4}, 32'h0);
        check("reset_done4", {31'b0, done4}, 32'h0);
        clear1 = 1'b0;
        clear4 = 1'b0;
        @(negedge clk);

        launch(1'b0, 3'b011, 32'h0000_0045, 5'd20, 32'h0004_5000, 1'b0, 20, "ror20_s1", 1'b1);
        wait_done(1'b0, "ror20_s1");
        @(negedge clk);

        launch(1'b1, 3'b001, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1, "shra4_s4", 1'b1);
        wait_done(1'b1, "shra4_s4");
        @(negedge clk);

        // SHL runs 8 cycles; a start pulse mid-shift must be dropped.
        launch(1'b1, 3'b010, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 8, "shl31_s4", 1'b1);
        start4 = 1'b1; op4 = 3'b100; a4 = 32'hFFFF_FFFF; amt4 = 5'd3;
        repeat (2) @(negedge clk);
        start4 = 1'b0;
        wait_done(1'b1, "shl31_s4");
        launch(1'b1, 3'b100, 32'h8000_0001, 5'd1, 32'h0000_0003, 1'b1, 1, "rol1_b2b", 1'b1);
        wait_done(1'b1, "rol1_b2b");
        launch(1'b1, 3'b010, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0, 0, "amt0_b2b", 1'b1);
        wait_done(1'b1, "amt0_b2b");
        launch(1'b1, 3'b111, 32'h1234_5678, 5'd9, 32'h1234_5678, 1'b0, 0, "illegal_b2b", 1'b1);
        wait_done(1'b1, "illegal_b2b");
        @(negedge clk);

        // Abort in the 5th SHIFT cycle; no done and no partial result may appear.
        launch(1'b0, 3'b011, 32'hDEAD_BEEF, 5'd20, 32'h0, 1'b0, 20, "aborted", 1'b0);
        repeat (4) @(negedge clk);
        clear1 = 1'b1;
        @(negedge clk);
        clear1 = 1'b0;
        check("clear_result", res1, 32'h0);
        check("clear_busy", {31'b0, busy1}, 32'h0);
        check("clear_done", {31'b0, done1}, 32'h0);
        @(negedge clk);

        launch(1'b0, 3'b000, 32'hF000_0000, 5'd8, 32'h00F0_0000, 1'b0, 8, "shr8_s1", 1'b1);
        wait_done(1'b0, "shr8_s1");

        repeat (4) @(negedge clk);
        check("queue1_drained", 32'(q1.size()), 32'd0);
        check("queue4_drained", 32'(q4.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
